// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and control-vector constants for the hazard sequencer
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        ILLEGAL    = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // One bit per pipeline-register control line driven by the sequencer
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_write;
    } ctrl_t;

    // Free-running pipeline: everything advances, nothing squashed
    localparam ctrl_t CTRL_DEFAULT = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
        idex_write: 1'b1, idex_bubble: 1'b0, exmem_write: 1'b1
    };

    // Whole pipeline frozen while data memory is busy
    localparam ctrl_t CTRL_HOLD = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
        idex_write: 1'b0, idex_bubble: 1'b0, exmem_write: 1'b0
    };

    // Drive NOPs through the front of the pipe while reset is held
    localparam ctrl_t CTRL_RESET = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
        idex_write: 1'b1, idex_bubble: 1'b1, exmem_write: 1'b1
    };

endpackage

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - saturating enable-driven event counter
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled cycles, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / branch / memory-wait sequencer for the 5-stage pipeline registers
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 64,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             jump_id,
    input  logic             branch_taken_ex,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout_err
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
    localparam int REM_W = 3;
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(MEM_TIMEOUT);
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_STALL_CYCLES - 1);

    state_t             state, state_nxt;
    logic [REM_W-1:0]   remaining, remaining_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    ctrl_t              ctrl;
    logic               lu;
    logic               mem_busy;

    // Hazard qualifiers: $zero never creates a dependency
    assign lu = ex_mem_read && (ex_rt != REG_ZERO) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign mem_busy = mem_req && !mem_ready;

    // Mealy control outputs and next-state selection
    always_comb begin
        ctrl          = CTRL_DEFAULT;
        state_nxt     = state;
        remaining_nxt = remaining;
        timer_nxt     = timer;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    ctrl      = CTRL_HOLD;
                    state_nxt = MEM_WAIT;
                    timer_nxt = TMR_W'(1);
                end else if (branch_taken_ex) begin
                    // Taken branch squashes both younger instructions; lu/jump belong to them
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_bubble = 1'b1;
                end else if (lu) begin
                    // Stall wins over a jump in ID; the jump flushes once the stall clears
                    ctrl.pc_write    = 1'b0;
                    ctrl.ifid_write  = 1'b0;
                    ctrl.idex_bubble = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_nxt     = LOAD_STALL;
                        remaining_nxt = REM_INIT;
                    end
                end else if (jump_id) begin
                    ctrl.ifid_flush = 1'b1;
                end
            end
            LOAD_STALL: begin
                if (mem_busy) begin
                    ctrl      = CTRL_HOLD;
                    state_nxt = MEM_WAIT;
                    timer_nxt = TMR_W'(1);
                end else if (branch_taken_ex) begin
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_bubble = 1'b1;
                    state_nxt        = RUN;
                end else begin
                    ctrl.pc_write    = 1'b0;
                    ctrl.ifid_write  = 1'b0;
                    ctrl.idex_bubble = 1'b1;
                    remaining_nxt    = remaining - REM_W'(1);
                    if (remaining == REM_W'(1)) begin
                        state_nxt = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                // EX is frozen here, so branch/lu get re-evaluated back in RUN
                if (mem_ready) begin
                    state_nxt = RUN;
                end else begin
                    ctrl = CTRL_HOLD;
                    if (timer != TMR_MAX) begin
                        timer_nxt = timer + TMR_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        if (reset) begin
            ctrl = CTRL_RESET;
        end
    end

    // FSM, stall/timeout bookkeeping and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RUN;
            remaining       <= '0;
            timer           <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            timer     <= timer_nxt;
            if ((state_nxt == MEM_WAIT) && (timer_nxt >= TMR_MAX)) begin
                mem_timeout_err <= 1'b1;
            end
        end
    end

    hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (!ctrl.pc_write),
        .count (stall_cycles)
    );

    hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl.ifid_flush),
        .count (flush_count)
    );

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_write  = ctrl.idex_write;
    assign idex_bubble = ctrl.idex_bubble;
    assign exmem_write = ctrl.exmem_write;
    assign state_o     = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic id_uses_rt, ex_mem_read, jump_id, branch_taken_ex, mem_req, mem_ready;

    logic a_pc_write, a_ifid_write, a_ifid_flush, a_idex_write, a_idex_bubble, a_exmem_write;
    logic [1:0]  a_state;
    logic [31:0] a_stall, a_flush;
    logic a_err;

    logic b_pc_write, b_ifid_write, b_ifid_flush, b_idex_write, b_idex_bubble, b_exmem_write;
    logic [1:0] b_state;
    logic [3:0] b_stall, b_flush;
    logic b_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut_a (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .jump_id(jump_id),
        .branch_taken_ex(branch_taken_ex), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
        .idex_write(a_idex_write), .idex_bubble(a_idex_bubble), .exmem_write(a_exmem_write),
        .state_o(a_state), .stall_cycles(a_stall), .flush_count(a_flush),
        .mem_timeout_err(a_err)
    );

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(64), .CNT_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .jump_id(jump_id),
        .branch_taken_ex(branch_taken_ex), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
        .idex_write(b_idex_write), .idex_bubble(b_idex_bubble), .exmem_write(b_exmem_write),
        .state_o(b_state), .stall_cycles(b_stall), .flush_count(b_flush),
        .mem_timeout_err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        jump_id = 1'b0; branch_taken_ex = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_lu();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    endtask

    initial begin
        logic [4:0] exp_mem;
        clr_in();
        reset = 1'b1;
        #1;
        // reset outputs {pc,ifid_w,flush,idex_w,bubble,exmem}
        chk("rst_ctrl_0", {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_write, a_idex_bubble, a_exmem_write}, 32'b001111);
        adv();
        chk("rst_ctrl_1", {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_write, a_idex_bubble, a_exmem_write}, 32'b001111);
        adv();
        reset = 1'b0;
        #1;
        chk("post_rst_state", a_state, 32'd0);
        chk("post_rst_stall", a_stall, 32'd0);
        chk("post_rst_flush", a_flush, 32'd0);
        chk("post_rst_ctrl", {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_write, a_idex_bubble, a_exmem_write}, 32'b110101);
        chk("post_rst_b_stall", b_stall, 32'd0);

        // single load-use hazard via rs
        set_lu();
        #1;
        chk("lu_ctrl", {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_write, a_idex_bubble, a_exmem_write}, 32'b000111);
        adv();
        clr_in();
        #1;
        chk("lu_after_ctrl", {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_write, a_idex_bubble, a_exmem_write}, 32'b110101);
        chk("lu_after_stall", a_stall, 32'd1);
        chk("lu3_state_1", b_state, 32'd1);
        chk("lu3_pc_1", b_pc_write, 32'd0);
        adv();
        chk("lu3_state_2", b_state, 32'd1);
        chk("lu3_pc_2", {b_pc_write, b_ifid_write, b_idex_bubble}, 32'b001);
        adv();
        chk("lu3_state_done", b_state, 32'd0);
        chk("lu3_pc_done", b_pc_write, 32'd1);
        chk("lu3_stall_cnt", b_stall, 32'd3);

        // no hazard on $zero, nor on rt when rt is not read
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk("lu_zero_reg", a_pc_write, 32'd1);
        adv();
        ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
        #1;
        chk("lu_rt_unused", a_pc_write, 32'd1);
        adv();
        id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_used", {a_pc_write, a_ifid_write, a_idex_bubble}, 32'b001);
        adv();
        clr_in();
        adv();
        adv();
        chk("lu_rt_b_back", b_state, 32'd0);
        chk("lu_rt_a_stall", a_stall, 32'd2);

        // taken branch beats lu and jump
        set_lu(); jump_id = 1'b1; branch_taken_ex = 1'b1;
        #1;
        chk("br_ctrl", {a_pc_write, a_ifid_flush, a_idex_bubble}, 32'b111);
        chk("br_b_ctrl", {b_pc_write, b_ifid_flush, b_idex_bubble}, 32'b111);
        adv();
        clr_in();
        #1;
        chk("br_flush_cnt", a_flush, 32'd1);
        chk("br_b_no_ls", b_state, 32'd0);

        // jump with lu: stall first, flush afterwards
        set_lu(); jump_id = 1'b1;
        #1;
        chk("jlu_stall", {a_pc_write, a_ifid_flush, a_idex_bubble}, 32'b001);
        adv();
        ex_mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk("jlu_flush", {a_pc_write, a_ifid_flush}, 32'b11);
        chk("jlu_b_no_flush", {b_pc_write, b_ifid_flush, b_state}, 32'b0001);
        adv();
        clr_in();
        #1;
        chk("jlu_flush_cnt", a_flush, 32'd2);
        adv();
        chk("jlu_b_back", b_state, 32'd0);

        // branch aborts a multi-cycle load stall
        set_lu();
        adv();
        clr_in(); branch_taken_ex = 1'b1;
        #1;
        chk("lsbr_b_ctrl", {b_state, b_pc_write, b_ifid_flush, b_idex_bubble}, 32'b01111);
        adv();
        clr_in();
        #1;
        chk("lsbr_b_state", b_state, 32'd0);
        chk("lsbr_a_flush", a_flush, 32'd3);
        chk("lsbr_a_stall", a_stall, 32'd4);

        // memory wait and timeout
        mem_req = 1'b1; mem_ready = 1'b0;
        branch_taken_ex = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            #1;
            exp_mem = {4'b0000, (i >= 65) ? 1'b1 : 1'b0};
            chk($sformatf("mem_hold_%0d", i),
                {a_pc_write, a_ifid_write, a_idex_write, a_exmem_write, a_err}, {27'd0, exp_mem});
            adv();
        end
        chk("mem_state", a_state, 32'd2);
        mem_ready = 1'b1;
        #1;
        chk("mem_ready_ctrl", {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_write, a_idex_bubble, a_exmem_write}, 32'b110101);
        adv();
        clr_in();
        #1;
        chk("mem_done_state", a_state, 32'd0);
        chk("mem_err_sticky", a_err, 32'd1);
        chk("mem_a_stall", a_stall, 32'd74);
        chk("mem_b_stall_sat", b_stall, 32'd15);
        adv();
        adv();
        chk("mem_err_still", {a_err, b_err}, 32'b11);

        reset = 1'b1;
        adv();
        reset = 1'b0;
        #1;
        chk("rst2_err", {a_err, b_err}, 32'b00);
        chk("rst2_stall", a_stall, 32'd0);
        chk("rst2_state", a_state, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
